pifo_level_arbiter: RTL and testbench

- Shares one level's push/pop lane of the PIFO tree among NREQ requesters, such as per-port queue managers.
- Grants round-robin, one grant per cycle, and drives the lane's push/pop/tree-id/data inputs.
- Honours the lane's task-FIFO-full backpressure.
- Routes level-0 pop results back to the requester that issued each pop, using an in-order tag FIFO.

---
 rtl/pifo_level_arbiter_if.sv | 54 +++++
 rtl/pifo_level_arbiter.sv | 135 +++++++++++++
 tb/tb_pifo_level_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pifo_level_arbiter_if.sv
// Signal bundle between NREQ requesters, one PIFO level lane and the arbiter that shares it.
// The environment (requesters plus lane) takes the master modport and the arbiter takes the slave modport.
interface pifo_level_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int PTW       = 3,
  parameter int MTW       = 8,
  parameter int PLW       = 7,
  parameter int TREE_NUM  = 4,
  parameter int TAG_DEPTH = 8
);
  localparam int TNB = $clog2(TREE_NUM);
  localparam int DW  = MTW + PTW + PLW;
  localparam int CW  = $clog2(TAG_DEPTH) + 1;

  // requester side
  logic [NREQ-1:0]     i_req_push;
  logic [NREQ-1:0]     i_req_pop;
  logic [NREQ*TNB-1:0] i_req_push_tree_id;
  logic [NREQ*TNB-1:0] i_req_pop_tree_id;
  logic [NREQ*DW-1:0]  i_req_push_data;
  logic [NREQ-1:0]     o_req_ready;
  logic [NREQ-1:0]     o_rsp_valid;
  logic [DW-1:0]       o_rsp_data;

  // lane side
  logic                o_push;
  logic [TNB-1:0]      o_push_tree_id;
  logic [DW-1:0]       o_push_data;
  logic                o_pop;
  logic [TNB-1:0]      o_pop_tree_id;
  logic                i_task_fifo_full;
  logic                i_is_level0_pop;
  logic [DW-1:0]       i_pop_data;

  // status
  logic [CW-1:0]       o_outstanding;
  logic                o_err_orphan;

  modport master (
    output i_req_push, i_req_pop, i_req_push_tree_id, i_req_pop_tree_id, i_req_push_data,
    output i_task_fifo_full, i_is_level0_pop, i_pop_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data,
    input  o_push, o_push_tree_id, o_push_data, o_pop, o_pop_tree_id,
    input  o_outstanding, o_err_orphan
  );

  modport slave (
    input  i_req_push, i_req_pop, i_req_push_tree_id, i_req_pop_tree_id, i_req_push_data,
    input  i_task_fifo_full, i_is_level0_pop, i_pop_data,
    output o_req_ready, o_rsp_valid, o_rsp_data,
    output o_push, o_push_tree_id, o_push_data, o_pop, o_pop_tree_id,
    output o_outstanding, o_err_orphan
  );
endinterface

// File: rtl/pifo_level_arbiter.sv
// Round-robin arbiter sharing one PIFO level push/pop lane among NREQ requesters.
// An in-order tag FIFO remembers which requester issued each pop, so level-0 results are routed back to it.
module pifo_level_arbiter #(
  parameter int NREQ      = 4,
  parameter int PTW       = 3,
  parameter int MTW       = 8,
  parameter int PLW       = 7,
  parameter int TREE_NUM  = 4,
  parameter int TAG_DEPTH = 8
) (
  input logic                 i_clk,
  input logic                 i_arst,
  pifo_level_arbiter_if.slave bus
);
  localparam int TNB = $clog2(TREE_NUM);
  localparam int DW  = MTW + PTW + PLW;
  localparam int RB  = $clog2(NREQ);
  localparam int AW  = $clog2(TAG_DEPTH);
  localparam int CW  = AW + 1;

  logic [RB-1:0]   rr_ptr;
  logic [RB-1:0]   tag_mem [TAG_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            tag_rd;
  logic            tag_wr;
  logic            tag_space;
  logic [NREQ-1:0] eligible;
  logic            grant_valid;
  logic [RB-1:0]   grant_idx;
  logic [RB-1:0]   cand;

  logic            push_q;
  logic            pop_q;
  logic [TNB-1:0]  push_id_q;
  logic [TNB-1:0]  pop_id_q;
  logic [DW-1:0]   push_data_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic [DW-1:0]   rsp_data_q;
  logic            err_orphan_q;

  // A result that arrives this cycle frees a tag slot in time for a new pop.
  assign tag_rd    = bus.i_is_level0_pop && (count != '0);
  assign tag_space = (count < CW'(TAG_DEPTH)) || tag_rd;

  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      eligible[r] = (bus.i_req_push[r] || bus.i_req_pop[r]) && !bus.i_task_fifo_full
                    && (!bus.i_req_pop[r] || tag_space);
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = rr_ptr + RB'(i);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign bus.o_req_ready = grant_valid ? (NREQ'(1) << grant_idx) : '0;
  assign tag_wr          = grant_valid && bus.i_req_pop[grant_idx];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      rr_ptr      <= '0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      push_id_q   <= '0;
      pop_id_q    <= '0;
      push_data_q <= '0;
    end else begin
      if (grant_valid) rr_ptr <= grant_idx + 1'b1;
      push_q      <= grant_valid && bus.i_req_push[grant_idx];
      pop_q       <= tag_wr;
      push_id_q   <= (grant_valid && bus.i_req_push[grant_idx])
                     ? bus.i_req_push_tree_id[int'(grant_idx)*TNB +: TNB] : '0;
      push_data_q <= (grant_valid && bus.i_req_push[grant_idx])
                     ? bus.i_req_push_data[int'(grant_idx)*DW +: DW] : '0;
      pop_id_q    <= tag_wr ? bus.i_req_pop_tree_id[int'(grant_idx)*TNB +: TNB] : '0;
    end
  end

  // NOTE: tag storage has no reset; only pointers and count define which entries are valid.
  always_ff @(posedge i_clk) begin
    if (tag_wr) tag_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (tag_wr) wr_ptr <= wr_ptr + 1'b1;
      if (tag_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({tag_wr, tag_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      rsp_valid_q  <= tag_rd ? (NREQ'(1) << tag_mem[rd_ptr]) : '0;
      rsp_data_q   <= bus.i_pop_data;
      if (bus.i_is_level0_pop && (count == '0)) err_orphan_q <= 1'b1;
    end
  end

  assign bus.o_push         = push_q;
  assign bus.o_push_tree_id = push_id_q;
  assign bus.o_push_data    = push_data_q;
  assign bus.o_pop          = pop_q;
  assign bus.o_pop_tree_id  = pop_id_q;
  assign bus.o_rsp_valid    = rsp_valid_q;
  assign bus.o_rsp_data     = rsp_data_q;
  assign bus.o_outstanding  = count;
  assign bus.o_err_orphan   = err_orphan_q;
endmodule

// File: tb/tb_pifo_level_arbiter.sv
// Bench for pifo_level_arbiter: directed scenarios followed by random traffic.
// Expectations come from a queue-based model of grants, the in-order pop routing and the orphan flag.
module tb_pifo_level_arbiter;
  localparam int NREQ      = 4;
  localparam int PTW       = 3;
  localparam int MTW       = 8;
  localparam int PLW       = 7;
  localparam int TREE_NUM  = 4;
  localparam int TAG_DEPTH = 8;
  localparam int TNB       = $clog2(TREE_NUM);
  localparam int DW        = MTW + PTW + PLW;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  pifo_level_arbiter_if #(
    .NREQ(NREQ), .PTW(PTW), .MTW(MTW), .PLW(PLW), .TREE_NUM(TREE_NUM), .TAG_DEPTH(TAG_DEPTH)
  ) bus ();

  pifo_level_arbiter #(
    .NREQ(NREQ), .PTW(PTW), .MTW(MTW), .PLW(PLW), .TREE_NUM(TREE_NUM), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_arst (arst),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // requester and lane stimulus
  bit             rq_push [NREQ];
  bit             rq_pop  [NREQ];
  logic [TNB-1:0] rq_pid  [NREQ];
  logic [TNB-1:0] rq_qid  [NREQ];
  logic [DW-1:0]  rq_data [NREQ];
  bit             full;
  bit             l0_pop;
  logic [DW-1:0]  l0_data;

  // reference model
  int m_ptr;
  int m_tags[$];
  bit m_orphan;
  int last_grant;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NREQ; r++) begin
      bus.i_req_push[r]                    = rq_push[r];
      bus.i_req_pop[r]                     = rq_pop[r];
      bus.i_req_push_tree_id[r*TNB +: TNB] = rq_pid[r];
      bus.i_req_pop_tree_id[r*TNB +: TNB]  = rq_qid[r];
      bus.i_req_push_data[r*DW +: DW]      = rq_data[r];
    end
    bus.i_task_fifo_full = full;
    bus.i_is_level0_pop  = l0_pop;
    bus.i_pop_data       = l0_data;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < NREQ; r++) begin
      rq_push[r] = 1'b0;
      rq_pop[r]  = 1'b0;
      rq_pid[r]  = '0;
      rq_qid[r]  = '0;
      rq_data[r] = '0;
    end
  endtask

  // One clock cycle: check the combinational grant, advance the model, check registered outputs.
  task automatic step();
    int              g;
    int              r;
    bit              rd;
    bit              space;
    logic [NREQ-1:0] e_ready;
    bit              e_push;
    bit              e_pop;
    logic [TNB-1:0]  e_pid;
    logic [TNB-1:0]  e_qid;
    logic [DW-1:0]   e_pdata;
    logic [NREQ-1:0] e_rsp;
    logic [DW-1:0]   e_rdata;
    drive();
    #1;
    rd    = l0_pop && (m_tags.size() > 0);
    space = (m_tags.size() < TAG_DEPTH) || rd;
    g = -1;
    if (!full) begin
      for (int i = 0; i < NREQ; i++) begin
        r = (m_ptr + i) % NREQ;
        if (g < 0 && (rq_push[r] || rq_pop[r]) && (!rq_pop[r] || space)) g = r;
      end
    end
    e_ready = (g >= 0) ? NREQ'(1 << g) : '0;
    check("req_ready", bus.o_req_ready, e_ready);

    e_push = 1'b0; e_pop = 1'b0; e_pid = '0; e_qid = '0; e_pdata = '0;
    if (g >= 0) begin
      e_push = rq_push[g];
      e_pop  = rq_pop[g];
      if (e_push) begin e_pid = rq_pid[g]; e_pdata = rq_data[g]; end
      if (e_pop) e_qid = rq_qid[g];
    end
    e_rsp = '0; e_rdata = '0;
    if (rd) begin
      e_rsp   = NREQ'(1 << m_tags.pop_front());
      e_rdata = l0_data;
    end else if (l0_pop) begin
      m_orphan = 1'b1;
    end
    if (g >= 0) begin
      if (rq_pop[g]) m_tags.push_back(g);
      m_ptr = (g + 1) % NREQ;
    end
    last_grant = g;

    @(posedge clk);
    #1;
    check("o_push", bus.o_push, e_push);
    check("o_push_tree_id", bus.o_push_tree_id, e_pid);
    check("o_push_data", bus.o_push_data, e_pdata);
    check("o_pop", bus.o_pop, e_pop);
    check("o_pop_tree_id", bus.o_pop_tree_id, e_qid);
    check("o_rsp_valid", bus.o_rsp_valid, e_rsp);
    if (e_rsp != '0) check("o_rsp_data", bus.o_rsp_data, e_rdata);
    check("o_outstanding", bus.o_outstanding, m_tags.size());
    check("o_err_orphan", bus.o_err_orphan, m_orphan);
  endtask

  task automatic release_granted();
    if (last_grant >= 0) begin
      rq_push[last_grant] = 1'b0;
      rq_pop[last_grant]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    clear_reqs();
    full    = 1'b0;
    l0_pop  = 1'b0;
    l0_data = '0;
    drive();
    @(posedge clk);
    #1;
    check("rst_req_ready", bus.o_req_ready, 0);
    check("rst_o_push", bus.o_push, 0);
    check("rst_o_pop", bus.o_pop, 0);
    check("rst_o_push_data", bus.o_push_data, 0);
    check("rst_o_rsp_valid", bus.o_rsp_valid, 0);
    check("rst_o_outstanding", bus.o_outstanding, 0);
    check("rst_o_err_orphan", bus.o_err_orphan, 0);
    m_ptr = 0;
    m_tags.delete();
    m_orphan   = 1'b0;
    last_grant = -1;
    arst = 1'b0;
  endtask

  initial begin
    int k;
    arst = 1'b1;
    do_reset();

    // single push from requester 0
    rq_push[0] = 1'b1; rq_pid[0] = 2'd1; rq_data[0] = 18'h1A5;
    step();
    check("single_push_data", bus.o_push_data, 18'h1A5);
    release_granted();
    step();

    // round-robin with all four pushing, then backpressure and resume
    do_reset();
    for (int r = 0; r < NREQ; r++) begin
      rq_push[r] = 1'b1; rq_pid[r] = TNB'(r); rq_data[r] = DW'($urandom);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      if (last_grant >= 0) rq_data[last_grant] = DW'($urandom);
    end
    full = 1'b1;
    for (int c = 0; c < 3; c++) step();
    full = 1'b0;
    for (int c = 0; c < 2; c++) step();

    // pop routing: requester 2 then requester 0
    do_reset();
    rq_pop[2] = 1'b1; rq_qid[2] = 2'd3;
    step(); release_granted();
    rq_pop[0] = 1'b1; rq_qid[0] = 2'd1;
    step(); release_granted();
    l0_pop = 1'b1; l0_data = 18'h011;
    step();
    l0_data = 18'h022;
    step();
    l0_pop = 1'b0;
    step();

    // tag FIFO full: stall a pop until a result frees a slot in the same cycle
    do_reset();
    for (int c = 0; c < TAG_DEPTH; c++) begin
      rq_pop[c % NREQ] = 1'b1; rq_qid[c % NREQ] = TNB'($urandom);
      step(); release_granted();
    end
    rq_pop[1] = 1'b1; rq_qid[1] = 2'd2;
    step();
    l0_pop = 1'b1; l0_data = DW'($urandom);
    step(); release_granted();
    for (int c = 0; c < TAG_DEPTH; c++) begin
      l0_data = DW'($urandom);
      step();
    end
    l0_pop = 1'b0;
    step();

    // orphan results: sticky until reset, including after a mid-operation reset
    l0_pop = 1'b1; l0_data = 18'h3FF;
    step();
    l0_pop = 1'b0;
    step(); step();
    rq_pop[3] = 1'b1;
    step(); release_granted();
    do_reset();
    l0_pop = 1'b1;
    step();
    l0_pop = 1'b0;
    step();

    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NREQ; r++) begin
        if (!rq_push[r] && !rq_pop[r] && ($urandom_range(1, 0) == 1)) begin
          k = $urandom_range(3, 1);
          rq_push[r] = k[0];
          rq_pop[r]  = k[1];
          rq_pid[r]  = TNB'($urandom);
          rq_qid[r]  = TNB'($urandom);
          rq_data[r] = DW'($urandom);
        end
      end
      full    = ($urandom_range(6, 0) == 0);
      l0_pop  = (m_tags.size() > 0) && ($urandom_range(2, 0) != 0);
      l0_data = DW'($urandom);
      step();
      release_granted();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
